// File: rtl/imem_loader.sv
// Boot-time IMEM loader: parses a framed byte stream (16-bit word count, LE payload, XOR check)
// into 32-bit IMEM writes and holds the core in reset until a frame verifies.
module imem_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {StHdr0, StHdr1, StPayload, StChk, StDone, StErr} state_e;

  localparam int unsigned Cap     = 32'd1 << ADDR_W;
  localparam logic [31:0] TmoLast = 32'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       word_q, word_d;
  logic [15:0]       idx_q, idx_d;
  logic [7:0]        xor_q, xor_d;
  logic [31:0]       tmo_q, tmo_d;
  logic              rx_ready_q, rx_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              xfer;
  logic [15:0]       n_full;
  logic [31:0]       word_nx;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    lane_d       = lane_q;
    word_d       = word_q;
    idx_d        = idx_q;
    xor_d        = xor_q;
    tmo_d        = tmo_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    err_code_d   = err_code_q;

    xfer    = rx_valid & rx_ready_q;
    n_full  = {rx_data, len_q[7:0]};
    // Bytes enter at the top so the first byte of a word ends up in [7:0].
    word_nx = {rx_data, word_q[31:8]};

    if (xfer) tmo_d = '0;

    unique case (state_q)
      StHdr0: begin
        tmo_d = '0;
        if (xfer) begin
          len_d[7:0] = rx_data;
          xor_d      = rx_data;
          state_d    = StHdr1;
        end
      end
      StHdr1: begin
        if (xfer) begin
          len_d = n_full;
          xor_d = xor_q ^ rx_data;
          if ({16'd0, n_full} > Cap) begin
            state_d    = StErr;
            err_code_d = 2'd1;
          end else if (n_full == 16'd0) begin
            state_d = StChk;
          end else begin
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (xfer) begin
          xor_d  = xor_q ^ rx_data;
          word_d = word_nx;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = idx_q[ADDR_W-1:0];
            imem_wdata_d = word_nx;
            idx_d        = idx_q + 16'd1;
            if (idx_q == len_q - 16'd1) state_d = StChk;
          end
        end
      end
      StChk: begin
        if (xfer) begin
          if (rx_data == xor_q) begin
            state_d = StDone;
          end else begin
            state_d    = StErr;
            err_code_d = 2'd2;
          end
        end
      end
      StDone, StErr: begin
        if (start) begin
          state_d    = StHdr0;
          idx_d      = '0;
          lane_d     = '0;
          xor_d      = '0;
          tmo_d      = '0;
          err_code_d = 2'd0;
        end
      end
      default: state_d = StHdr0;
    endcase

    // An accepted byte in the same cycle always beats the timeout.
    if (!xfer && (state_q == StHdr1 || state_q == StPayload || state_q == StChk)) begin
      tmo_d = tmo_q + 32'd1;
      if (tmo_d == TmoLast) begin
        state_d    = StErr;
        err_code_d = 2'd3;
      end
    end

    rx_ready_d  = (state_d != StDone) && (state_d != StErr);
    cpu_rst_d   = (state_d != StDone);
    load_done_d = (state_d == StDone);
    load_err_d  = (state_d == StErr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StHdr0;
      len_q        <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      idx_q        <= '0;
      xor_q        <= '0;
      tmo_q        <= '0;
      rx_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      xor_q        <= xor_d;
      tmo_q        <= tmo_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame table, hand-written timing corners and random throttled frames
// checked against a byte-level frame model.
module tb_imem_loader;

  localparam int unsigned AW  = 8;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          start = 1'b0;
  logic          rx_ready, imem_we, cpu_rst, load_done, load_err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [1:0]    err_code;

  imem_loader #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .load_err   (load_err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] prog [10] = '{32'h040300b7, 32'h20108093, 32'h08070137, 32'h60510113,
                             32'h00400193, 32'h2020850b, 32'hfff18193, 32'hfe019ce3,
                             32'h00a02023, 32'h0180066f};

  logic [7:0]  frm[$];
  logic [39:0] act_q[$];
  logic [39:0] exp_q[$];
  bit          exp_done;
  logic [1:0]  exp_code;
  int          nb;

  always @(negedge clk) if (rst && imem_we) act_q.push_back({imem_addr, imem_wdata});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 50) begin
      tick();
      n++;
    end
    if (!rx_ready) begin
      tests++;
      fails++;
      $display("FAIL rx_ready_wait: got 0 expected 1");
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int maxgap);
    for (int i = first; i <= last; i++)
      send_byte(frm[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
  endtask

  function automatic logic [31:0] word(input int i);
    return prog[i % 10] ^ (32'(i / 10) * 32'h11111111);
  endfunction

  task automatic build_frame(input int n, input logic [7:0] flip, input bit rnd);
    logic [7:0]  x;
    logic [31:0] w;
    logic [15:0] nn;
    nn = 16'(n);
    frm.delete();
    frm.push_back(nn[7:0]);
    frm.push_back(nn[15:8]);
    if (n <= (1 << AW)) begin
      for (int i = 0; i < n; i++) begin
        w = rnd ? $urandom : word(i);
        for (int k = 0; k < 4; k++) frm.push_back(w[8*k +: 8]);
      end
      x = 8'd0;
      foreach (frm[i]) x ^= frm[i];
      frm.push_back(x ^ flip);
    end
  endtask

  // Reference: interpret the frame bytes directly from the format rules.
  task automatic model();
    int         n;
    logic [7:0] x;
    exp_q.delete();
    n = int'({frm[1], frm[0]});
    if (n > (1 << AW)) begin
      exp_done = 1'b0;
      exp_code = 2'd1;
      nb       = 2;
      return;
    end
    x = 8'd0;
    for (int i = 0; i < 2 + 4 * n; i++) x ^= frm[i];
    for (int w = 0; w < n; w++)
      exp_q.push_back({8'(w), frm[2+4*w+3], frm[2+4*w+2], frm[2+4*w+1], frm[2+4*w]});
    nb       = 2 + 4 * n + 1;
    exp_done = (frm[2+4*n] == x);
    exp_code = exp_done ? 2'd0 : 2'd2;
  endtask

  task automatic check_model_result();
    int m;
    check("nwr", act_q.size(), exp_q.size());
    m = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check("wr", act_q[i], exp_q[i]);
    check("load_done", load_done, exp_done);
    check("load_err", load_err, !exp_done);
    check("err_code", err_code, exp_code);
    check("cpu_rst", cpu_rst, !exp_done);
    check("rx_ready_end", rx_ready, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 1);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_cpu_rst"}, cpu_rst, 1);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_load_err"}, load_err, 0);
    check({tag, "_err_code"}, err_code, 0);
  endtask

  typedef struct {
    int         n;
    logic [7:0] flip;
    int         nwr;
    bit         done;
    logic [1:0] code;
  } vec_t;

  vec_t vt[7];

  initial begin
    int m;
    vt[0] = '{10,  8'h00, 10,  1'b1, 2'd0};
    vt[1] = '{10,  8'h01, 10,  1'b0, 2'd2};
    vt[2] = '{257, 8'h00, 0,   1'b0, 2'd1};
    vt[3] = '{0,   8'h00, 0,   1'b1, 2'd0};
    vt[4] = '{0,   8'h80, 0,   1'b0, 2'd2};
    vt[5] = '{1,   8'h00, 1,   1'b1, 2'd0};
    vt[6] = '{256, 8'h00, 256, 1'b1, 2'd0};

    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("reset");

    // HDR0 never times out.
    repeat (40) tick();
    check("hdr0_idle_err", load_err, 0);
    check("hdr0_idle_ready", rx_ready, 1);

    foreach (vt[r]) begin
      pulse_start();
      build_frame(vt[r].n, vt[r].flip, 1'b0);
      act_q.delete();
      send_range(0, frm.size() - 1, 0);
      tick();
      check("tbl_nwr", act_q.size(), vt[r].nwr);
      m = (act_q.size() < vt[r].nwr) ? act_q.size() : vt[r].nwr;
      for (int i = 0; i < m; i++) check("tbl_wr", act_q[i], {8'(i), word(i)});
      check("tbl_done", load_done, vt[r].done);
      check("tbl_err", load_err, !vt[r].done);
      check("tbl_code", err_code, vt[r].code);
      check("tbl_cpu_rst", cpu_rst, !vt[r].done);
      check("tbl_rx_ready", rx_ready, 0);
    end

    // Strobe one cycle after the 4th byte; cpu_rst falls right after the CHK byte.
    pulse_start();
    build_frame(10, 8'h00, 1'b0);
    act_q.delete();
    send_range(0, 5, 0);
    check("strobe_we", imem_we, 1);
    check("strobe_addr", imem_addr, 0);
    check("strobe_data", imem_wdata, 32'h040300b7);
    send_range(6, 41, 0);
    check("pre_chk_cpu_rst", cpu_rst, 1);
    check("pre_chk_done", load_done, 0);
    send_range(42, 42, 0);
    check("post_chk_cpu_rst", cpu_rst, 0);
    check("post_chk_done", load_done, 1);
    model();
    check_model_result();

    // start while loading payload is ignored.
    pulse_start();
    build_frame(10, 8'h00, 1'b0);
    act_q.delete();
    send_range(0, 9, 0);
    pulse_start();
    send_range(10, frm.size() - 1, 0);
    tick();
    model();
    check_model_result();

    // Timeout after payload byte 5.
    pulse_start();
    build_frame(10, 8'h00, 1'b0);
    act_q.delete();
    send_range(0, 6, 0);
    repeat (14) tick();
    check("tmo_early_err", load_err, 0);
    tick();
    check("tmo_err", load_err, 1);
    check("tmo_code", err_code, 3);
    check("tmo_ready", rx_ready, 0);
    check("tmo_cpu_rst", cpu_rst, 1);
    check("tmo_nwr", act_q.size(), 1);
    repeat (5) tick();

    // start in ERR clears the flags on the next edge.
    pulse_start();
    check("restart_err", load_err, 0);
    check("restart_code", err_code, 0);
    check("restart_cpu_rst", cpu_rst, 1);
    check("restart_ready", rx_ready, 1);
    check("restart_done", load_done, 0);

    // Reset in the middle of word 3, then a fresh load.
    build_frame(10, 8'h00, 1'b0);
    send_range(0, 15, 0);
    rst = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b1;
    tick();
    act_q.delete();
    model();
    send_range(0, nb - 1, 0);
    tick();
    check_model_result();

    // Random frames with throttled delivery.
    for (int t = 0; t < 30; t++) begin
      int         n;
      logic [7:0] flip;
      pulse_start();
      if ($urandom_range(0, 7) == 0) n = 257 + int'($urandom_range(0, 100));
      else n = int'($urandom_range(0, 12));
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      build_frame(n, flip, 1'b1);
      act_q.delete();
      model();
      send_range(0, nb - 1, 10);
      tick();
      check_model_result();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the `riscv_cpu` instruction memory. It accepts a framed byte stream (header, payload, checksum) over a valid/ready byte interface and assembles little-endian 32-bit words. It writes them through the IMEM write port and holds the core in reset until a frame loads cleanly. It replaces hierarchical `IMEM.mem[]` preloading, so the custom-MAC programs run unchanged on silicon and FPGA.

## Interface
- `ADDR_W`, 8: IMEM word-address width; capacity is 2^ADDR_W words.
- `TIMEOUT`, 100000: maximum idle cycles allowed between bytes once a frame has started.

- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `rx_data`  in  8: incoming byte.
- `rx_valid`  in  1: `rx_data` is valid.
- `rx_ready`  out  1: loader can accept a byte; a transfer occurs when `rx_valid & rx_ready`.
- `start`  in  1: single-cycle request to begin a new load; honoured only in DONE or ERR.
- `imem_we`  out  1: IMEM write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W: IMEM word address.
- `imem_wdata`  out  32: IMEM write data.
- `cpu_rst`  out  1: core reset, active-high; asserted until a load succeeds.
- `load_done`  out  1: last frame loaded and verified.
- `load_err`  out  1: last frame failed.
- `err_code`  out  2: 0 none, 1 length too large, 2 checksum mismatch, 3 timeout.

## Operation
- Frame format:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - N×4 payload bytes; the first byte of each word maps to bits [7:0].
  - One CHK byte equal to the XOR of every preceding frame byte, including the header.
- FSM states: HDR0, HDR1, PAYLOAD, CHK, DONE, ERR. Reset and `start` both enter HDR0.
- HDR0: wait indefinitely for the first byte; latch LEN_LO and seed the XOR with it.
- HDR1: latch LEN_HI.
  - N > 2^ADDR_W: go to ERR, code 1.
  - N == 0: go to CHK.
  - Otherwise: go to PAYLOAD.
- PAYLOAD:
  - A 2-bit byte lane counter shifts bytes into a word register.
  - On the 4th byte, register the write: `imem_we`=1, `imem_addr`=word index, `imem_wdata`=assembled word. The strobe appears the cycle after that byte is accepted.
  - The word index starts at 0 and increments after each write.
  - After word N-1 is written, go to CHK.
- CHK:
  - Byte equals the running XOR: go to DONE.
  - Otherwise: go to ERR, code 2.
- DONE: `cpu_rst`=0, `load_done`=1, `rx_ready`=0.
- ERR: `cpu_rst`=1, `load_err`=1, `err_code` held, `rx_ready`=0.
- `start` in DONE or ERR:
  - Next cycle is HDR0 with `cpu_rst`=1 and `load_done`/`load_err`/`err_code` cleared.
  - Word index, lane counter, XOR and timeout counter are all cleared.
- `start` in any other state is ignored.
- Timeout:
  - The counter clears on every accepted byte and on entry to HDR0.
  - It increments each cycle in HDR1, PAYLOAD and CHK with no transfer.
  - Reaching TIMEOUT-1 goes to ERR, code 3.
  - A byte accepted in the same cycle wins over the timeout.
- IMEM writes already issued before an error are not undone; the core stays in reset.
- `rx_ready` is a registered decode of state: 1 in HDR0, HDR1, PAYLOAD and CHK. It does not depend combinationally on `rx_valid`.

## Timing
- Reset values: `rx_ready`=1 (state HDR0), `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_rst`=1, `load_done`=0, `load_err`=0, `err_code`=0.
- Reset takes effect on the next rising edge wherever the FSM is, including mid-word. Partial word, index and XOR are discarded; `cpu_rst` returns to 1 immediately.
- One byte is accepted per cycle maximum, with no bubbles required.
- The IMEM write occurs 1 cycle after the word's 4th byte. The CHK byte may be accepted in that same cycle.
- `cpu_rst` falls 1 cycle after the CHK byte is accepted (the DONE-entry edge). `load_done` rises on the same edge.
- The error flags rise on the edge the FSM enters ERR.

## Test plan
- Good load: N=10 words 040300b7, 20108093, 08070137, 60510113, 00400193, 2020850b, fff18193, fe019ce3, 00a02023, 0180066f, correct XOR.
  - Required: 10 `imem_we` pulses at addr 0..9 with exactly that data, then `cpu_rst`=0 and `load_done`=1.
  - With the core running ~700 ns: DMEM[0]=280 and x3=0.
- Bad checksum: same frame with CHK XOR 0x01 -> 10 writes occur; `load_err`=1, `err_code`=2, `cpu_rst` stays 1.
- Oversize: ADDR_W=8, N=257 -> ERR code 1 after LEN_HI; no `imem_we`; `rx_ready`=0.
- Timeout: TIMEOUT=16, stall 20 cycles after payload byte 5 -> ERR code 3 at the 15th idle cycle after the last byte. An idle period of any length in HDR0 never times out.
- Throttled stream: random `rx_valid` gaps (≤10 cycles, TIMEOUT=16) on the good frame -> identical writes and result as the good-load case.
- Reset/restart:
  - `rst`=0 mid-word of word 3 -> outputs return to reset values next edge; a fresh good frame then loads correctly.
  - `start` pulsed in ERR -> flags clear and a new frame loads.
  - `start` pulsed in PAYLOAD -> no effect.
